// File: rtl/pma_check_sequencer.sv
// Shared iterative PMA attribute checker: round-robin grant, then one rule index per cycle.
// Optional macro PMA_CHECK_EARLY_EXIT_EN ends the scan as soon as all three attributes have hit.
module pma_check_sequencer #(
    parameter int unsigned               NrReq                 = 3,
    parameter int unsigned               MaxRules              = 16,
    parameter int unsigned               NrNonIdempotentRules  = 0,
    parameter logic [MaxRules-1:0][63:0] NonIdempotentAddrBase = '0,
    parameter logic [MaxRules-1:0][63:0] NonIdempotentLength   = '0,
    parameter int unsigned               NrExecuteRegionRules  = 0,
    parameter logic [MaxRules-1:0][63:0] ExecuteRegionAddrBase = '0,
    parameter logic [MaxRules-1:0][63:0] ExecuteRegionLength   = '0,
    parameter int unsigned               NrCachedRegionRules   = 0,
    parameter logic [MaxRules-1:0][63:0] CachedRegionAddrBase  = '0,
    parameter logic [MaxRules-1:0][63:0] CachedRegionLength    = '0,
    parameter int unsigned               IdW                   = (NrReq > 1) ? $clog2(NrReq) : 1
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   flush_i,
    input  logic [NrReq-1:0]       req_valid_i,
    input  logic [NrReq-1:0][63:0] req_addr_i,
    output logic [NrReq-1:0]       req_ready_o,
    output logic                   rsp_valid_o,
    input  logic                   rsp_ready_i,
    output logic [IdW-1:0]         rsp_id_o,
    output logic                   rsp_nonidem_o,
    output logic                   rsp_exec_o,
    output logic                   rsp_cached_o
);

    localparam int unsigned NiEx    = (NrNonIdempotentRules > NrExecuteRegionRules) ?
                                      NrNonIdempotentRules : NrExecuteRegionRules;
    localparam int unsigned N       = (NiEx > NrCachedRegionRules) ? NiEx : NrCachedRegionRules;
    localparam int unsigned LastIdx = (N > 0) ? N - 1 : 0;
    localparam int unsigned IdxW    = (MaxRules > 1) ? $clog2(MaxRules) : 1;
    localparam int          NrReqI  = int'(NrReq);

    typedef enum logic [1:0] {IDLE, SCAN, RESP} state_e;

    state_e            r_state;
    state_e            w_stateNext;
    logic [63:0]       r_addr;
    logic [IdW-1:0]    r_id;
    logic [IdW-1:0]    r_rrPtr;
    logic [IdxW-1:0]   r_idx;
    logic              r_accNi;
    logic              r_accEx;
    logic              r_accCa;
    logic              w_grantFound;
    logic [IdW-1:0]    w_grantId;
    logic              w_grant;
    logic              w_hitNi;
    logic              w_hitEx;
    logic              w_hitCa;
    logic              w_scanDone;
    logic              w_resp;

    // The 65-bit end address keeps regions that touch the top of the address space from wrapping.
    function automatic logic regionHit(input logic [63:0] addr, input logic [63:0] base,
                                       input logic [63:0] len);
        return (addr >= base) && ({1'b0, addr} < ({1'b0, base} + {1'b0, len}));
    endfunction

    always_comb begin
        w_grantFound = 1'b0;
        w_grantId    = '0;
        for (int j = 0; j < NrReqI; j++) begin
            if (!w_grantFound && req_valid_i[j] && (j >= int'(r_rrPtr))) begin
                w_grantFound = 1'b1;
                w_grantId    = IdW'(j);
            end
        end
        for (int j = 0; j < NrReqI; j++) begin
            if (!w_grantFound && req_valid_i[j] && (j < int'(r_rrPtr))) begin
                w_grantFound = 1'b1;
                w_grantId    = IdW'(j);
            end
        end
    end

    assign w_grant = (r_state == IDLE) && !flush_i && !rst_i && w_grantFound;

    always_comb begin
        req_ready_o = '0;
        for (int j = 0; j < NrReqI; j++) begin
            req_ready_o[j] = w_grant && (w_grantId == IdW'(j));
        end
    end

    assign w_hitNi = (32'(r_idx) < NrNonIdempotentRules) &&
                     regionHit(r_addr, NonIdempotentAddrBase[r_idx], NonIdempotentLength[r_idx]);
    assign w_hitEx = (32'(r_idx) < NrExecuteRegionRules) &&
                     regionHit(r_addr, ExecuteRegionAddrBase[r_idx], ExecuteRegionLength[r_idx]);
    assign w_hitCa = (32'(r_idx) < NrCachedRegionRules) &&
                     regionHit(r_addr, CachedRegionAddrBase[r_idx], CachedRegionLength[r_idx]);

`ifdef PMA_CHECK_EARLY_EXIT_EN
    assign w_scanDone = (r_idx == IdxW'(LastIdx)) ||
                        ((r_accNi || w_hitNi) && (r_accEx || w_hitEx) && (r_accCa || w_hitCa));
`else
    assign w_scanDone = (r_idx == IdxW'(LastIdx));
`endif

    always_comb begin
        w_stateNext = r_state;
        unique case (r_state)
            IDLE:    if (w_grant) w_stateNext = (N > 0) ? SCAN : RESP;
            SCAN:    if (w_scanDone) w_stateNext = RESP;
            RESP:    if (rsp_ready_i) w_stateNext = IDLE;
            default: w_stateNext = IDLE;
        endcase
        if (flush_i) begin
            w_stateNext = IDLE;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    // Accumulators only advance during an unflushed scan; a flushed request leaves no trace.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_addr  <= '0;
            r_id    <= '0;
            r_rrPtr <= '0;
            r_idx   <= '0;
            r_accNi <= 1'b0;
            r_accEx <= 1'b0;
            r_accCa <= 1'b0;
        end else if (w_grant) begin
            r_addr  <= req_addr_i[w_grantId];
            r_id    <= w_grantId;
            r_rrPtr <= (w_grantId == IdW'(NrReq - 1)) ? '0 : w_grantId + 1'b1;
            r_idx   <= '0;
            r_accNi <= 1'b0;
            r_accEx <= 1'b0;
            r_accCa <= 1'b0;
        end else if ((r_state == SCAN) && !flush_i) begin
            r_accNi <= r_accNi | w_hitNi;
            r_accEx <= r_accEx | w_hitEx;
            r_accCa <= r_accCa | w_hitCa;
            r_idx   <= r_idx + 1'b1;
        end
    end

    assign w_resp        = (r_state == RESP);
    assign rsp_valid_o   = w_resp;
    assign rsp_id_o      = w_resp ? r_id : '0;
    assign rsp_nonidem_o = w_resp && r_accNi;
    assign rsp_exec_o    = w_resp && ((NrExecuteRegionRules == 0) ? 1'b1 : r_accEx);
    assign rsp_cached_o  = w_resp && r_accCa;

endmodule
